// File: rtl/console_writer.sv
// Write side of the console text RAMs: turns a byte stream into character/attribute
// writes, tracks the cursor, and scrolls by bumping the row offset and blanking a line.
module console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] BLANK_ATTR = 8'h0F
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [7:0]  DATA_IN,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  input  logic [7:0]  ATTR_IN,
  output logic [12:0] RAM_WR_ADDRESS,
  output logic [7:0]  RAM_CHAR_WDATA,
  output logic [7:0]  RAM_ATTR_WDATA,
  output logic        RAM_CHAR_WE,
  output logic        RAM_ATTR_WE,
  output logic [7:0]  RAM_ROW_OFFSET,
  output logic [6:0]  CURSOR_COL,
  output logic [5:0]  CURSOR_ROW,
  output logic        BUSY
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRITE, CLEAR_LINE} state_t;

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [13:0] ALL_DONE  = 14'd8192;
  localparam logic [13:0] LINE_DONE = 14'(COLS);

  function automatic logic is_printable(input logic [7:0] b);
    return b >= 8'h20;
  endfunction

  state_t      state, state_n;
  logic [13:0] sweep, sweep_n;
  logic [6:0]  col, col_n;
  logic [5:0]  row, row_n;
  logic [5:0]  offset, offset_n;
  logic [7:0]  code, code_n;
  logic [12:0] addr, addr_n;
  logic [7:0]  char_data, char_n;
  logic [7:0]  attr_data, attr_n;
  logic        we, we_n;
  logic        newline;

  always_comb begin
    state_n  = state;
    sweep_n  = sweep;
    col_n    = col;
    row_n    = row;
    offset_n = offset;
    code_n   = code;
    addr_n   = addr;
    char_n   = char_data;
    attr_n   = attr_data;
    we_n     = 1'b0;
    newline  = 1'b0;
    case (state)
      CLEAR_ALL: begin
        if (sweep == ALL_DONE) begin
          state_n = IDLE;
        end else begin
          we_n    = 1'b1;
          addr_n  = sweep[12:0];
          char_n  = BLANK_CHAR;
          attr_n  = BLANK_ATTR;
          sweep_n = sweep + 14'd1;
        end
      end
      IDLE: begin
        if (DATA_VALID) begin
          code_n  = DATA_IN;
          state_n = WRITE;
          // Printable bytes are written straight from the accept edge so the
          // strobe lands in the WRITE cycle; WRITE then only moves the cursor.
          if (is_printable(DATA_IN)) begin
            we_n   = 1'b1;
            addr_n = {row + offset, col};
            char_n = DATA_IN;
            attr_n = ATTR_IN;
          end
        end
      end
      WRITE: begin
        state_n = IDLE;
        case (code)
          8'h0D: col_n = '0;
          8'h0A: newline = 1'b1;
          8'h08: if (col != 7'd0) col_n = col - 7'd1;
          8'h0C: begin
            col_n    = '0;
            row_n    = '0;
            offset_n = '0;
            sweep_n  = '0;
            state_n  = CLEAR_ALL;
          end
          default: begin
            if (is_printable(code)) begin
              if (col == LAST_COL) begin
                col_n   = '0;
                newline = 1'b1;
              end else begin
                col_n = col + 7'd1;
              end
            end
          end
        endcase
        if (newline) begin
          if (row != LAST_ROW) begin
            row_n = row + 6'd1;
          end else begin
            // Scroll: the first blank of the exposed line is issued here so the
            // line clear takes exactly COLS cycles in CLEAR_LINE.
            offset_n = offset + 6'd1;
            state_n  = CLEAR_LINE;
            we_n     = 1'b1;
            addr_n   = {LAST_ROW + offset + 6'd1, 7'd0};
            char_n   = BLANK_CHAR;
            attr_n   = BLANK_ATTR;
            sweep_n  = 14'd1;
          end
        end
      end
      CLEAR_LINE: begin
        if (sweep == LINE_DONE) begin
          state_n = IDLE;
        end else begin
          we_n    = 1'b1;
          addr_n  = {LAST_ROW + offset, sweep[6:0]};
          char_n  = BLANK_CHAR;
          attr_n  = BLANK_ATTR;
          sweep_n = sweep + 14'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= CLEAR_ALL;
      sweep     <= '0;
      col       <= '0;
      row       <= '0;
      offset    <= '0;
      code      <= '0;
      addr      <= '0;
      char_data <= '0;
      attr_data <= '0;
      we        <= 1'b0;
    end else begin
      state     <= state_n;
      sweep     <= sweep_n;
      col       <= col_n;
      row       <= row_n;
      offset    <= offset_n;
      code      <= code_n;
      addr      <= addr_n;
      char_data <= char_n;
      attr_data <= attr_n;
      we        <= we_n;
    end
  end

  assign DATA_READY     = (state == IDLE);
  assign BUSY           = (state == CLEAR_ALL) || (state == CLEAR_LINE);
  assign RAM_WR_ADDRESS = addr;
  assign RAM_CHAR_WDATA = char_data;
  assign RAM_ATTR_WDATA = attr_data;
  assign RAM_CHAR_WE    = we;
  assign RAM_ATTR_WE    = we;
  assign RAM_ROW_OFFSET = {2'b00, offset};
  assign CURSOR_COL     = col;
  assign CURSOR_ROW     = row;

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer: screen clear, printable writes, wrap, scroll,
// offset wrap, control codes, held-valid acceptance and reset during a line clear.
module tb_console_writer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [7:0]  DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic [7:0]  ATTR_IN;
  logic [12:0] RAM_WR_ADDRESS;
  logic [7:0]  RAM_CHAR_WDATA;
  logic [7:0]  RAM_ATTR_WDATA;
  logic        RAM_CHAR_WE;
  logic        RAM_ATTR_WE;
  logic [7:0]  RAM_ROW_OFFSET;
  logic [6:0]  CURSOR_COL;
  logic [5:0]  CURSOR_ROW;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  console_writer dut (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .ATTR_IN(ATTR_IN), .RAM_WR_ADDRESS(RAM_WR_ADDRESS),
    .RAM_CHAR_WDATA(RAM_CHAR_WDATA), .RAM_ATTR_WDATA(RAM_ATTR_WDATA),
    .RAM_CHAR_WE(RAM_CHAR_WE), .RAM_ATTR_WE(RAM_ATTR_WE),
    .RAM_ROW_OFFSET(RAM_ROW_OFFSET), .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!DATA_READY && g < 20000) begin
      @(negedge CLK);
      g++;
    end
    if (!DATA_READY) check({tag, "_ready_timeout"}, 32'(DATA_READY), 32'd1);
  endtask

  // Returns at the falling edge of the cycle after the accept (the WRITE cycle).
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    wait_ready("send");
    DATA_IN    = d;
    ATTR_IN    = a;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_clear_all(input string tag);
    int n = 0;
    int bad = 0;
    int g = 0;
    while (n < 8192 && g < 9000) begin
      @(negedge CLK);
      g++;
      if (RAM_CHAR_WE) begin
        if (RAM_WR_ADDRESS != 13'(n) || RAM_CHAR_WDATA != 8'h20 || RAM_ATTR_WDATA != 8'h0F ||
            !RAM_ATTR_WE || DATA_READY || !BUSY) bad++;
        n++;
      end else if (n > 0) begin
        bad++;
      end
    end
    check({tag, "_we_count"}, 32'(n), 32'd8192);
    check({tag, "_sequence"}, 32'(bad), 32'd0);
    @(negedge CLK);
    check({tag, "_ready_after"}, 32'(DATA_READY), 32'd1);
    check({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    check({tag, "_we_after"}, 32'(RAM_CHAR_WE), 32'd0);
  endtask

  task automatic wait_clear_line(input string tag, input logic [12:0] base);
    int n = 0;
    int bad = 0;
    int g = 0;
    while (n < 80 && g < 200) begin
      @(negedge CLK);
      g++;
      if (RAM_CHAR_WE) begin
        if (RAM_WR_ADDRESS != base + 13'(n) || RAM_CHAR_WDATA != 8'h20 ||
            RAM_ATTR_WDATA != 8'h0F || !RAM_ATTR_WE || DATA_READY || !BUSY) bad++;
        n++;
      end else if (n > 0) begin
        bad++;
      end
    end
    check({tag, "_we_count"}, 32'(n), 32'd80);
    check({tag, "_sequence"}, 32'(bad), 32'd0);
    @(negedge CLK);
    check({tag, "_ready_after"}, 32'(DATA_READY), 32'd1);
  endtask

  initial begin
    logic [12:0] a79;
    logic [12:0] a80;
    int g;

    RSTN       = 1'b0;
    DATA_VALID = 1'b0;
    DATA_IN    = 8'h00;
    ATTR_IN    = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_we", 32'(RAM_CHAR_WE), 32'd0);
    check("rst_ready", 32'(DATA_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_addr", 32'(RAM_WR_ADDRESS), 32'd0);
    check("rst_wdata", 32'({RAM_CHAR_WDATA, RAM_ATTR_WDATA}), 32'd0);
    check("rst_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'd0);
    check("rst_offset", 32'(RAM_ROW_OFFSET), 32'd0);
    RSTN = 1'b1;
    wait_clear_all("clr0");

    // single printable at home
    send(8'h41, 8'h1E);
    check("a_we", 32'(RAM_CHAR_WE), 32'd1);
    check("a_attr_we", 32'(RAM_ATTR_WE), 32'd1);
    check("a_addr", 32'(RAM_WR_ADDRESS), 32'h0000);
    check("a_char", 32'(RAM_CHAR_WDATA), 32'h41);
    check("a_attr", 32'(RAM_ATTR_WDATA), 32'h1E);
    @(negedge CLK);
    check("a_we_pulse", 32'(RAM_CHAR_WE), 32'd0);
    check("a_col", 32'(CURSOR_COL), 32'd1);

    // 81 printables from home: wrap to row 1
    send(8'h0D, 8'h00);
    a79 = '0;
    a80 = '0;
    for (int i = 0; i < 81; i++) begin
      send(8'h30 + 8'(i % 40), 8'h07);
      if (i == 79) a79 = RAM_WR_ADDRESS;
      if (i == 80) a80 = RAM_WR_ADDRESS;
    end
    check("wrap_80th_addr", 32'(a79), 32'h004F);
    check("wrap_81st_addr", 32'(a80), 32'h0080);
    @(negedge CLK);
    check("wrap_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'({6'd1, 7'd1}));

    // move to row 29 and scroll once
    send(8'h0D, 8'h00);
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
    @(negedge CLK);
    check("row29", 32'(CURSOR_ROW), 32'd29);
    check("row29_offset", 32'(RAM_ROW_OFFSET), 32'd0);
    send(8'h0A, 8'h00);
    wait_clear_line("scroll1", 13'h0F00);
    check("scroll1_offset", 32'(RAM_ROW_OFFSET), 32'd1);
    check("scroll1_row", 32'(CURSOR_ROW), 32'd29);

    // advance offset to 63, then wrap it to 0
    for (int i = 0; i < 62; i++) begin
      send(8'h0A, 8'h00);
      wait_ready("scroll_n");
    end
    check("offset63", 32'(RAM_ROW_OFFSET), 32'd63);
    send(8'h0A, 8'h00);
    wait_clear_line("scroll_wrap", 13'h0E80);
    check("offset_wrap", 32'(RAM_ROW_OFFSET), 32'd0);

    // full last row: char written first, then scroll
    send(8'h0D, 8'h00);
    a79 = '0;
    for (int i = 0; i < 80; i++) begin
      send(8'h61 + 8'(i % 26), 8'h0F);
      if (i == 79) a79 = RAM_WR_ADDRESS;
    end
    check("lastrow_char_addr", 32'(a79), 32'h0ECF);
    wait_clear_line("lastrow_scroll", 13'h0F00);
    check("lastrow_offset", 32'(RAM_ROW_OFFSET), 32'd1);
    check("lastrow_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'({6'd29, 7'd0}));

    // BS at column 0, BS after a char, ignored control code
    send(8'h08, 8'h00);
    check("bs0_we", 32'(RAM_CHAR_WE), 32'd0);
    @(negedge CLK);
    check("bs0_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'({6'd29, 7'd0}));
    send(8'h5A, 8'h0F);
    send(8'h08, 8'h00);
    @(negedge CLK);
    check("bs1_col", 32'(CURSOR_COL), 32'd0);
    send(8'h01, 8'h00);
    check("ctl_we", 32'(RAM_CHAR_WE), 32'd0);
    @(negedge CLK);
    check("ctl_cursor", 32'({RAM_ROW_OFFSET, CURSOR_ROW, CURSOR_COL}), 32'({8'd1, 6'd29, 7'd0}));

    // FF with a byte held valid throughout the clear
    send(8'h0C, 8'h00);
    DATA_IN    = 8'h42;
    ATTR_IN    = 8'h07;
    DATA_VALID = 1'b1;
    wait_clear_all("ff");
    check("ff_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'd0);
    check("ff_offset", 32'(RAM_ROW_OFFSET), 32'd0);
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
    @(negedge CLK);
    check("held_we", 32'(RAM_CHAR_WE), 32'd1);
    check("held_addr", 32'(RAM_WR_ADDRESS), 32'h0000);
    check("held_char", 32'(RAM_CHAR_WDATA), 32'h42);
    check("held_attr", 32'(RAM_ATTR_WDATA), 32'h07);

    // reset in the middle of a line clear
    send(8'h0D, 8'h00);
    for (int i = 0; i < 29; i++) send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    g = 0;
    while (!(RAM_CHAR_WE && RAM_WR_ADDRESS[6:0] == 7'd40) && g < 200) begin
      @(negedge CLK);
      g++;
    end
    check("mid_clear_addr", 32'(RAM_WR_ADDRESS), 32'h0F28);
    check("mid_clear_offset", 32'(RAM_ROW_OFFSET), 32'd1);
    RSTN = 1'b0;
    @(negedge CLK);
    check("rst2_we", 32'(RAM_CHAR_WE), 32'd0);
    check("rst2_offset", 32'(RAM_ROW_OFFSET), 32'd0);
    check("rst2_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'd0);
    check("rst2_busy", 32'(BUSY), 32'd1);
    RSTN = 1'b1;
    wait_clear_all("rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
